// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode and FSM encodings for the logic unit arbiter.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the issue slots and the shared logic unit arbiter.
interface logic_unit_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  // Requesters plus the result consumer.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational bitwise logic unit: AND / OR / XOR / NAND.
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Decode the opcode into one bitwise operation.
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between NREQ requesters.
// Accept in IDLE, compute in EXEC, hold the registered result in RESP until taken.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  logic_unit_arbiter_if.slave    bus
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   win;
  logic             any_valid;
  logic [NREQ-1:0]  req_ready;

  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] lu_y;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  // First valid requester after the last winner, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    logic           found;
    int unsigned    idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && valid[IDW'(idx)]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_valid = |bus.req_valid;
  assign win       = rr_pick(bus.req_valid, last_q);

  // Route the winner's opcode and operands to the capture registers.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_op = bus.req_op[2*i +: 2];
        sel_a  = bus.req_a[WIDTH*i +: WIDTH];
        sel_b  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; any unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: grant strobe only in IDLE, and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && any_valid) begin
      req_ready[win] = 1'b1;
    end
  end

  // Capture the winner on accept and register the result leaving EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= IDW'(NREQ - 1);
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_valid) begin
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= win;
            last_q <= win;
          end
        end
        StExec: begin
          rsp_data_q  <= lu_y;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        StResp: begin
          // rsp_data deliberately keeps its value after the handshake.
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_id_q    <= '0;
          rsp_data_q  <= '0;
        end
      endcase
    end
  end

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (lu_y)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
